// File: rtl/core_pkg.sv
// Shared types and instruction field positions for the 9-bit accumulator ISA.
package core_pkg;

    // Top-level control states of the multi-cycle core.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } state_t;

    // ALU opcodes (inst[7:4] when inst[8]=1); values 7..15 are NOPs.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6
    } alu_op_t;

    // Non-ALU sub-opcodes (inst[7:5] when inst[8]=0).
    typedef enum logic [2:0] {
        SUB_MVA  = 3'd0,
        SUB_MVR  = 3'd1,
        SUB_LD   = 3'd2,
        SUB_ST   = 3'd3,
        SUB_LDI  = 3'd4,
        SUB_BZ   = 3'd5,
        SUB_BC   = 3'd6,
        SUB_HALT = 3'd7
    } sub_op_t;

    // Instruction field positions.
    localparam int INST_W       = 9;
    localparam int INST_ALU_BIT = 8;
    localparam int OP_LSB       = 4;
    localparam int OP_W         = 4;
    localparam int SUB_LSB      = 5;
    localparam int SUB_W        = 3;
    localparam int IMM_W        = 5;

    // Condition flags.
    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

endpackage

// File: rtl/core_alu.sv
// Combinational ALU: res = a OP b with flag results; upd=0 marks a NOP opcode.
// Shifts move a by one position; b is ignored for them.
module core_alu
    import core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o,
    output flags_t            flags_o,
    output logic              upd_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0]   ext;
    logic [DATA_W-1:0] res;
    logic              c_flag;
    logic              v_flag;

    // Opcode decode and result/carry/overflow generation.
    always_comb begin
        ext    = '0;
        res    = a_i;
        c_flag = 1'b0;
        v_flag = 1'b0;
        upd_o  = 1'b1;
        case (op_i)
            ALU_ADD: begin
                ext    = {1'b0, a_i} + {1'b0, b_i};
                res    = ext[DATA_W-1:0];
                c_flag = ext[DATA_W];
                v_flag = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                ext    = {1'b0, a_i} - {1'b0, b_i};
                res    = ext[DATA_W-1:0];
                c_flag = ext[DATA_W];      // borrow
                v_flag = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            ALU_AND: res = a_i & b_i;
            ALU_OR:  res = a_i | b_i;
            ALU_XOR: res = a_i ^ b_i;
            ALU_SHL: begin
                res    = {a_i[DATA_W-2:0], 1'b0};
                c_flag = a_i[MSB];
            end
            ALU_SHR: begin
                res    = {1'b0, a_i[DATA_W-1:1]};
                c_flag = a_i[0];
            end
            default: upd_o = 1'b0;
        endcase
        res_o     = res;
        flags_o.z = (res == '0);
        flags_o.c = c_flag;
        flags_o.n = res[MSB];
        flags_o.v = v_flag;
    end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle accumulator core: FETCH/EXEC/MEM sequencer with req/valid
// handshakes to external instruction and data memories.
// Optional feature macro CORE_PERF_CNT_EN adds cycle_cnt/instret_cnt outputs.
module mc_core
    import core_pkg::*;
#(
    parameter int PC_WIDTH  = 11,
    parameter int REG_WIDTH = 4,
    parameter int DATA_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                done,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [INST_W-1:0]   imem_data,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_valid,
    input  logic [DATA_W-1:0]   dmem_rdata
`ifdef CORE_PERF_CNT_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instret_cnt
`endif
);

    localparam int NUM_REGS = 1 << REG_WIDTH;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    flags_t                flags_q, flags_d;
    logic [INST_W-1:0]     inst_q, inst_d;

    logic [DATA_W-1:0]     gpr_q [NUM_REGS];
    logic                  gpr_we;
    logic [REG_WIDTH-1:0]  idx;
    logic [DATA_W-1:0]     gpr_rd;

    logic                  is_alu;
    sub_op_t               sub;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   pc_br;

    logic [DATA_W-1:0]     alu_res;
    flags_t                alu_flags;
    logic                  alu_upd;

    assign idx        = inst_q[REG_WIDTH-1:0];
    assign gpr_rd     = gpr_q[idx];
    assign is_alu     = inst_q[INST_ALU_BIT];
    assign sub        = sub_op_t'(inst_q[SUB_LSB +: SUB_W]);
    assign pc_inc     = pc_q + PC_WIDTH'(1);
    assign pc_br      = pc_q + {{(PC_WIDTH-IMM_W){inst_q[IMM_W-1]}}, inst_q[IMM_W-1:0]};

    assign imem_addr  = pc_q;
    assign dmem_addr  = gpr_rd;
    assign dmem_wdata = acc_q;

    core_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i    (inst_q[OP_LSB +: OP_W]),
        .a_i     (acc_q),
        .b_i     (gpr_rd),
        .res_o   (alu_res),
        .flags_o (alu_flags),
        .upd_o   (alu_upd)
    );

    // Next-state, architectural updates and handshake outputs.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        flags_d  = flags_q;
        inst_d   = inst_q;
        gpr_we   = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    inst_d  = imem_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_inc;
                if (is_alu) begin
                    if (alu_upd) begin
                        acc_d   = alu_res;
                        flags_d = alu_flags;
                    end
                end else begin
                    case (sub)
                        SUB_MVA:  acc_d  = gpr_rd;
                        SUB_MVR:  gpr_we = 1'b1;
                        SUB_LD,
                        SUB_ST: begin
                            // pc advances only once the data access completes
                            state_d = MEM;
                            pc_d    = pc_q;
                        end
                        SUB_LDI:  acc_d = DATA_W'(inst_q[IMM_W-1:0]);
                        SUB_BZ:   pc_d  = flags_q.z ? pc_br : pc_inc;
                        SUB_BC:   pc_d  = flags_q.c ? pc_br : pc_inc;
                        SUB_HALT: begin
                            state_d = HALT;
                            pc_d    = pc_q;
                        end
                        default: ;
                    endcase
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (sub == SUB_ST);
                if (dmem_valid) begin
                    if (sub == SUB_LD) begin
                        acc_d = dmem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            HALT: begin
                done = 1'b1;
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
            flags_q <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            inst_q  <= inst_d;
        end
    end

    // General-purpose registers; written from acc by MVR.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_gpr
        logic [DATA_W-1:0] r_q;

        // One register: cleared on reset, loaded when MVR selects it.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_q <= '0;
            end else if (gpr_we && (idx == REG_WIDTH'(gi))) begin
                r_q <= acc_q;
            end
        end

        assign gpr_q[gi] = r_q;
    end

`ifdef CORE_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_cnt_q;
    logic        start_accept;

    assign start_accept = start && ((state_q == IDLE) || (state_q == HALT));

    // Busy-cycle and retired-instruction counters, restarted with each run.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q inside {FETCH, EXEC, MEM}) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (state_q == EXEC) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    // Counters not built; core behaviour is otherwise the same.
`endif

endmodule

// File: tb/tb_mc_core.sv
// Directed testbench for mc_core: small programs in a behavioural
// instruction memory, a data memory with programmable wait states.
module tb_mc_core;

    localparam int PC_WIDTH  = 11;
    localparam int REG_WIDTH = 4;
    localparam int DATA_W    = 8;

    localparam int S_IDLE  = 0;
    localparam int S_FETCH = 1;
    localparam int S_EXEC  = 2;
    localparam int S_MEM   = 3;
    localparam int S_HALT  = 4;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_XOR = 4;
    localparam int OP_SHL = 5;
    localparam int OP_NOP9 = 9;

    localparam int C_MVR  = 1;
    localparam int C_LD   = 2;
    localparam int C_ST   = 3;
    localparam int C_LDI  = 4;
    localparam int C_BZ   = 5;
    localparam int C_BC   = 6;
    localparam int C_HALT = 7;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                done;
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_valid;
    logic [8:0]          imem_data;
    logic                dmem_req;
    logic                dmem_we;
    logic [DATA_W-1:0]   dmem_addr;
    logic [DATA_W-1:0]   dmem_wdata;
    logic                dmem_valid;
    logic [DATA_W-1:0]   dmem_rdata;
`ifdef CORE_PERF_CNT_EN
    logic [31:0]         cycle_cnt;
    logic [31:0]         instret_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mc_core #(
        .PC_WIDTH  (PC_WIDTH),
        .REG_WIDTH (REG_WIDTH),
        .DATA_W    (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_valid (dmem_valid),
        .dmem_rdata (dmem_rdata)
`ifdef CORE_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: answers in the request cycle unless stalled.
    logic [8:0] imem_mem [2048];
    logic       imem_stall;
    assign imem_valid = imem_req && !imem_stall;
    assign imem_data  = imem_mem[imem_addr];

    // Data memory: valid after dmem_wait waiting cycles; loads return ld_data.
    int         dmem_wait;
    int         dwait_cnt  = 0;
    logic [7:0] ld_data;
    int         n_writes   = 0;
    logic [7:0] last_waddr = 8'h00;
    logic [7:0] last_wdata = 8'h00;
    assign dmem_valid = dmem_req && (dwait_cnt >= dmem_wait);
    assign dmem_rdata = ld_data;

    always @(posedge clk) begin
        if (dmem_req && !dmem_valid) dwait_cnt <= dwait_cnt + 1;
        else                         dwait_cnt <= 0;
        if (dmem_req && dmem_valid && dmem_we) begin
            n_writes   <= n_writes + 1;
            last_waddr <= dmem_addr;
            last_wdata <= dmem_wdata;
        end
    end

    // Bus monitor sampled on the falling edge.
    int   req_cyc  = 0;
    int   unstable = 0;
    int   overlap  = 0;
    logic mon_en;
    always @(negedge clk) begin
        if (dmem_req) req_cyc <= req_cyc + 1;
        if (imem_req && dmem_req) overlap <= overlap + 1;
        if (mon_en && dmem_req &&
            (dmem_addr !== 8'h10 || dmem_we !== 1'b1 || dmem_wdata !== 8'h15))
            unstable <= unstable + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] enc_alu(input int op, input int r);
        enc_alu = {1'b1, op[3:0], r[3:0]};
    endfunction

    function automatic logic [8:0] enc_ctl(input int sub, input int low);
        enc_ctl = {1'b0, sub[2:0], low[4:0]};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 2048; i++) imem_mem[i] = enc_ctl(C_HALT, 0);
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        $display("RUN %s cycles=%0d pc=0x%0h acc=0x%0h", tag, cyc, dut.pc_q, dut.acc_q);
    endtask

    task automatic run(input string tag, output int cyc);
        kick();
        wait_done(tag, cyc);
    endtask

    int cyc;
    int req0;
    int w0;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        imem_stall = 1'b0;
        dmem_wait  = 0;
        ld_data    = 8'h7F;
        mon_en     = 1'b0;
        clear_imem();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(dut.state_q), S_IDLE);
        chk("rst_pc",    32'(dut.pc_q), 32'd0);
        chk("rst_acc",   32'(dut.acc_q), 32'd0);
        chk("rst_flags", 32'(dut.flags_q), 32'd0);
        chk("rst_reqs",  32'({done, imem_req, dmem_req, dmem_we}), 32'd0);
        reset = 1'b0;

        // Zero-wait program: LDI 5; MVR r1; LDI 3; ADD r1; HALT
        clear_imem();
        imem_mem[0] = enc_ctl(C_LDI, 5);
        imem_mem[1] = enc_ctl(C_MVR, 1);
        imem_mem[2] = enc_ctl(C_LDI, 3);
        imem_mem[3] = enc_alu(OP_ADD, 1);
        run("progA", cyc);
        chk("progA_cycles", 32'(cyc), 32'd10);
        chk("progA_acc",    32'(dut.acc_q), 32'h08);
        chk("progA_zc",     32'({dut.flags_q.z, dut.flags_q.c}), 32'd0);
        chk("progA_pc",     32'(dut.pc_q), 32'd4);
`ifdef CORE_PERF_CNT_EN
        chk("progA_cyccnt", cycle_cnt, 32'd10);
        chk("progA_instret", instret_cnt, 32'd5);
`endif

        // Restart from HALT
        kick();
        chk("restart_done",  32'(done), 32'd0);
        chk("restart_state", 32'(dut.state_q), S_FETCH);
        chk("restart_pc",    32'(dut.pc_q), 32'd0);
`ifdef CORE_PERF_CNT_EN
        chk("restart_cyccnt",  cycle_cnt, 32'd0);
        chk("restart_instret", instret_cnt, 32'd0);
`endif
        wait_done("progA_again", cyc);
        chk("progA2_acc", 32'(dut.acc_q), 32'h08);

        // Signed overflow: LDI 1; MVR r2; LD r0 (0x7F); ADD r2; HALT
        clear_imem();
        imem_mem[0] = enc_ctl(C_LDI, 1);
        imem_mem[1] = enc_ctl(C_MVR, 2);
        imem_mem[2] = enc_ctl(C_LD, 0);
        imem_mem[3] = enc_alu(OP_ADD, 2);
        run("add_ovf", cyc);
        chk("add_cycles", 32'(cyc), 32'd11);
        chk("add_acc",    32'(dut.acc_q), 32'h80);
        chk("add_flags",  32'(dut.flags_q), 32'b0010 | 32'b0001);  // n=1 v=1, z=0 c=0

        // Borrow: LDI 0; SUB r2; NOP(op 9); HALT
        clear_imem();
        imem_mem[0] = enc_ctl(C_LDI, 0);
        imem_mem[1] = enc_alu(OP_SUB, 2);
        imem_mem[2] = enc_alu(OP_NOP9, 2);
        run("sub_borrow", cyc);
        chk("sub_acc",   32'(dut.acc_q), 32'hFF);
        chk("sub_flags", 32'(dut.flags_q), 32'b0110);   // c=1 n=1

        // XOR r2 (0xFE, c cleared); SHL r2 (0xFC, c=1)
        clear_imem();
        imem_mem[0] = enc_alu(OP_XOR, 2);
        imem_mem[1] = enc_alu(OP_SHL, 2);
        run("xor_shl", cyc);
        chk("shl_acc",   32'(dut.acc_q), 32'hFC);
        chk("shl_flags", 32'(dut.flags_q), 32'b0110);

        // Store with 4 wait states: LDI 16; MVR r3; LDI 21; ST r3; HALT
        clear_imem();
        imem_mem[0] = enc_ctl(C_LDI, 16);
        imem_mem[1] = enc_ctl(C_MVR, 3);
        imem_mem[2] = enc_ctl(C_LDI, 21);
        imem_mem[3] = enc_ctl(C_ST, 3);
        req0 = req_cyc;
        w0   = n_writes;
        dmem_wait = 4;
        mon_en    = 1'b1;
        run("store_wait", cyc);
        mon_en    = 1'b0;
        dmem_wait = 0;
        chk("st_cycles",   32'(cyc), 32'd15);
        chk("st_req_cyc",  32'(req_cyc - req0), 32'd5);
        chk("st_writes",   32'(n_writes - w0), 32'd1);
        chk("st_addr",     32'(last_waddr), 32'h10);
        chk("st_data",     32'(last_wdata), 32'h15);
        chk("st_stable",   32'(unstable), 32'd0);
        chk("st_pc",       32'(dut.pc_q), 32'd4);

        // Set z: LDI 1; SUB r2; HALT
        clear_imem();
        imem_mem[0] = enc_ctl(C_LDI, 1);
        imem_mem[1] = enc_alu(OP_SUB, 2);
        run("set_z", cyc);
        chk("setz_flags", 32'(dut.flags_q), 32'b1000);

        // BZ -1 at pc 0 wraps to 0x7FF; then reset while stalled in FETCH
        clear_imem();
        imem_mem[0]     = enc_ctl(C_BZ, 5'h1F);
        imem_mem[2047]  = enc_ctl(C_BC, 5);
        kick();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bz_wrap_pc",    32'(dut.pc_q), 32'h7FF);
        chk("bz_wrap_state", 32'(dut.state_q), S_FETCH);
        imem_stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_req",  32'(imem_req), 32'd1);
        chk("stall_pc",   32'(dut.pc_q), 32'h7FF);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req",   32'(imem_req), 32'd0);
        chk("midrst_pc",    32'(dut.pc_q), 32'd0);
        chk("midrst_state", 32'(dut.state_q), S_IDLE);
        chk("midrst_done",  32'(done), 32'd0);
        reset      = 1'b0;
        imem_stall = 1'b0;

        // BC +3 with c=0 is not taken: halts at pc 1
        clear_imem();
        imem_mem[0] = enc_ctl(C_BC, 3);
        run("bc_not_taken", cyc);
        chk("bc_pc",     32'(dut.pc_q), 32'd1);
        chk("bc_cycles", 32'(cyc), 32'd4);

        chk("req_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
